// File: rtl/de1_io_pkg.sv
// Shared DE1 I/O definitions: debounce FSM encodings, 50 MHz timing
// defaults and button polarity helpers.
package de1_io_pkg;

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_CHK = 2'd3
    } btn_state_e;

    // 20 ms, 500 ms and 200 ms at 50 MHz
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_REPEAT_DELAY    = 25_000_000;
    localparam int DEF_REPEAT_PERIOD   = 10_000_000;

    function automatic logic released_level(input logic active_low);
        return active_low;
    endfunction

    function automatic logic is_pressed(
        input logic sample,
        input logic active_low
    );
        return sample ^ active_low;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with a selectable reset level.
// Shared by the button conditioner and the HC-SR04 echo input.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: synchronize, debounce, emit press/release pulses.
// Optional auto-repeat of press pulses when BTN_AUTOREPEAT_EN is defined.
module btn_debounce_pulse
    import de1_io_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter logic ACTIVE_LOW      = 1'b1,
    parameter int   REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int   REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int             CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES);

`ifdef BTN_AUTOREPEAT_EN
    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1)
    begin : g_bad_cfg
        $error("btn_debounce_pulse: illegal timing parameters");
    end
`else
    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 0 || REPEAT_PERIOD < 0)
    begin : g_bad_cfg
        $error("btn_debounce_pulse: illegal timing parameters");
    end
`endif

    logic          w_sync;
    logic          w_pressed;
    logic [CW-1:0] w_count_inc;

    btn_state_e    r_state;
    logic [CW-1:0] r_count;
    logic          r_level;
    logic          r_press;
    logic          r_release;

    sync_2ff #(
        .RESET_VAL (released_level(ACTIVE_LOW))
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (btn_in),
        .o_q   (w_sync)
    );

    assign w_pressed   = is_pressed(w_sync, ACTIVE_LOW);
    assign w_count_inc = (r_count == CNT_MAX) ? r_count : r_count + CNT_ONE;

`ifdef BTN_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                          REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] r_rep;
    logic          r_rep_first;
    logic          w_rep_hit;

    // First repeat waits the long delay, later ones the short period
    assign w_rep_hit = (r_rep == (r_rep_first ? RD_LAST : RP_LAST));
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= RELEASED;
            r_count     <= '0;
            r_level     <= 1'b0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            r_rep       <= '0;
            r_rep_first <= 1'b1;
`endif
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;

            unique case (r_state)
                RELEASED: begin
                    if (w_pressed) begin
                        r_state <= PRESS_CHK;
                        r_count <= CNT_ONE;
                    end else begin
                        r_count <= '0;
                    end
                end
                PRESS_CHK: begin
                    if (!w_pressed) begin
                        r_state <= RELEASED;
                        r_count <= '0;
                    end else begin
                        r_count <= w_count_inc;
                        if (w_count_inc == CNT_MAX) begin
                            r_state <= PRESSED;
                            r_level <= 1'b1;
                            r_press <= 1'b1;
                        end
                    end
                end
                PRESSED: begin
                    if (!w_pressed) begin
                        r_state <= RELEASE_CHK;
                        r_count <= CNT_ONE;
                    end else begin
                        r_count <= '0;
                    end
                end
                RELEASE_CHK: begin
                    if (w_pressed) begin
                        r_state <= PRESSED;
                        r_count <= '0;
                    end else begin
                        r_count <= w_count_inc;
                        if (w_count_inc == CNT_MAX) begin
                            r_state   <= RELEASED;
                            r_level   <= 1'b0;
                            r_release <= 1'b1;
                        end
                    end
                end
            endcase

`ifdef BTN_AUTOREPEAT_EN
            // Only a steady hold in PRESSED advances the repeat timer
            if (r_state != PRESSED || !w_pressed) begin
                r_rep       <= '0;
                r_rep_first <= 1'b1;
            end else if (w_rep_hit) begin
                r_rep       <= '0;
                r_rep_first <= 1'b0;
                r_press     <= 1'b1;
            end else begin
                r_rep <= r_rep + RW'(1);
            end
`endif
        end
    end

    assign btn_level     = r_level;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Self-checking bench for btn_debounce_pulse against a run-length
// reference model; build with BTN_AUTOREPEAT_EN to cover auto-repeat.
module tb_btn_debounce_pulse;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_in = 1'b1;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;

    int n_checks = 0;
    int n_fail = 0;

    // reference model state
    logic m1, m2;
    logic mL;
    int   mrun;
    int   mhold;
    logic el, ep, er;

    btn_debounce_pulse #(
        .DEBOUNCE_CYCLES (D),
        .ACTIVE_LOW      (1'b1),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_in        (btn_in),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m1 = 1'b1;
        m2 = 1'b1;
        mL = 1'b0;
        mrun = 0;
        mhold = 0;
        el = 1'b0;
        ep = 1'b0;
        er = 1'b0;
    endtask

    // A level is accepted after D consecutive differing samples, where
    // the sample seen at an edge is the pin value two edges earlier.
    task automatic model_step();
        logic s;
        s = (m2 == 1'b0);
        m2 = m1;
        m1 = btn_in;
        ep = 1'b0;
        er = 1'b0;
        if (s != mL) begin
            mrun++;
            if (mL) mhold = 0;
            if (mrun == D) begin
                mL = s;
                mrun = 0;
                mhold = 0;
                if (s) ep = 1'b1;
                else er = 1'b1;
            end
        end else begin
            if (mL) begin
                if (mrun > 0) begin
                    mhold = 0;
                end else begin
                    mhold++;
`ifdef BTN_AUTOREPEAT_EN
                    if (mhold == RD ||
                        (mhold > RD && (mhold - RD) % RP == 0))
                        ep = 1'b1;
`endif
                end
            end
            mrun = 0;
        end
        el = mL;
    endtask

    task automatic tick(input logic b);
        btn_in = b;
        @(posedge clk);
        if (!reset) model_step();
        #1;
    endtask

    task automatic settle(input logic b, input int n);
        for (int i = 0; i < n; i++) tick(b);
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({btn_level, press_pulse, release_pulse} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_state: got %b exp 000",
                     {btn_level, press_pulse, release_pulse});
        end
        model_reset();
        settle(1'b1, 3);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1'b1);
            n_checks++;
            if ({btn_level, press_pulse, release_pulse} !== {el, ep, er}) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d: got %b exp %b", i,
                         {btn_level, press_pulse, release_pulse}, {el, ep, er});
            end
        end
    endtask

    task automatic test_clean_press();
        int first = -1;
        int pulses = 0;
        for (int i = 1; i <= 12; i++) begin
            tick(1'b0);
            if (press_pulse) begin
                pulses++;
                if (first < 0) first = i;
            end
            n_checks++;
            if ({btn_level, press_pulse, release_pulse} !== {el, ep, er}) begin
                n_fail++;
                $display("FAIL clean_press cyc %0d: got %b exp %b", i,
                         {btn_level, press_pulse, release_pulse}, {el, ep, er});
            end
        end
        n_checks++;
        if (first !== D + 2) begin
            n_fail++;
            $display("FAIL press_latency: got edge %0d exp %0d", first, D + 2);
        end
        n_checks++;
        if (pulses !== 1 || btn_level !== 1'b1) begin
            n_fail++;
            $display("FAIL press_once: got %0d pulses level %b exp 1 and 1",
                     pulses, btn_level);
        end
    endtask

    task automatic test_release();
        int first = -1;
        logic lvl_at = 1'bx;
        for (int i = 1; i <= 12; i++) begin
            tick(1'b1);
            if (release_pulse && first < 0) begin
                first = i;
                lvl_at = btn_level;
            end
            n_checks++;
            if ({btn_level, press_pulse, release_pulse} !== {el, ep, er}) begin
                n_fail++;
                $display("FAIL release cyc %0d: got %b exp %b", i,
                         {btn_level, press_pulse, release_pulse}, {el, ep, er});
            end
        end
        n_checks++;
        if (first !== D + 2 || lvl_at !== 1'b0) begin
            n_fail++;
            $display("FAIL release_latency: got edge %0d level %b exp %0d and 0",
                     first, lvl_at, D + 2);
        end
    endtask

    task automatic test_bounce_reject();
        int pulses = 0;
        for (int i = 0; i < 14; i++) begin
            tick((i < 3) ? 1'b0 : 1'b1);
            pulses += int'(press_pulse) + int'(release_pulse);
            n_checks++;
            if ({btn_level, press_pulse, release_pulse} !== {el, ep, er}) begin
                n_fail++;
                $display("FAIL bounce_reject cyc %0d: got %b exp %b", i,
                         {btn_level, press_pulse, release_pulse}, {el, ep, er});
            end
        end
        n_checks++;
        if (pulses !== 0 || btn_level !== 1'b0) begin
            n_fail++;
            $display("FAIL bounce_quiet: got %0d pulses level %b exp 0 and 0",
                     pulses, btn_level);
        end
    endtask

    task automatic test_bouncy_press();
        int first = -1;
        int pulses = 0;
        for (int i = 1; i <= 20; i++) begin
            tick((i <= 6) ? logic'((i - 1) % 2) : 1'b0);
            if (press_pulse) begin
                pulses++;
                if (first < 0) first = i;
            end
            n_checks++;
            if ({btn_level, press_pulse, release_pulse} !== {el, ep, er}) begin
                n_fail++;
                $display("FAIL bouncy_press cyc %0d: got %b exp %b", i,
                         {btn_level, press_pulse, release_pulse}, {el, ep, er});
            end
        end
        n_checks++;
        if (pulses !== 1 || first !== 7 + D + 1) begin
            n_fail++;
            $display("FAIL bouncy_once: got %0d pulses at %0d exp 1 at %0d",
                     pulses, first, 7 + D + 1);
        end
        settle(1'b1, 12);
    endtask

    task automatic test_reset_mid_hold();
        int first = -1;
        settle(1'b0, 9);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({btn_level, press_pulse, release_pulse} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_async: got %b exp 000",
                     {btn_level, press_pulse, release_pulse});
        end
        model_reset();
        settle(1'b0, 3);
        reset = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick(1'b0);
            if (press_pulse && first < 0) first = i;
            n_checks++;
            if ({btn_level, press_pulse, release_pulse} !== {el, ep, er}) begin
                n_fail++;
                $display("FAIL reset_rehold cyc %0d: got %b exp %b", i,
                         {btn_level, press_pulse, release_pulse}, {el, ep, er});
            end
        end
        n_checks++;
        if (first !== D + 2) begin
            n_fail++;
            $display("FAIL reset_repress: got edge %0d exp %0d", first, D + 2);
        end
        settle(1'b1, 12);
    endtask

    task automatic test_autorepeat();
        int pulses = 0;
        int late = 0;
        int exp_p;
`ifdef BTN_AUTOREPEAT_EN
        exp_p = 7;
`else
        exp_p = 1;
`endif
        for (int i = 1; i <= 44; i++) begin
            tick((i <= 30) ? 1'b0 : 1'b1);
            pulses += int'(press_pulse);
            n_checks++;
            if ({btn_level, press_pulse, release_pulse} !== {el, ep, er}) begin
                n_fail++;
                $display("FAIL autorepeat cyc %0d: got %b exp %b", i,
                         {btn_level, press_pulse, release_pulse}, {el, ep, er});
            end
        end
        for (int i = 0; i < 20; i++) begin
            tick(1'b1);
            late += int'(press_pulse);
        end
        n_checks++;
        if (pulses !== exp_p || late !== 0) begin
            n_fail++;
            $display("FAIL repeat_count: got %0d then %0d exp %0d then 0",
                     pulses, late, exp_p);
        end
    endtask

    task automatic test_random();
        int cyc = 0;
        while (cyc < 600) begin
            logic lvl;
            int len;
            lvl = logic'($urandom_range(0, 1));
            len = (($urandom & 3) == 0) ? $urandom_range(6, 40)
                                        : $urandom_range(1, 7);
            for (int k = 0; k < len; k++) begin
                tick(lvl);
                cyc++;
                n_checks++;
                if ({btn_level, press_pulse, release_pulse} !== {el, ep, er}
                    || (press_pulse && release_pulse)) begin
                    n_fail++;
                    $display("FAIL random cyc %0d: got %b exp %b", cyc,
                             {btn_level, press_pulse, release_pulse},
                             {el, ep, er});
                end
            end
        end
        settle(1'b1, 12);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_release();
        test_bounce_reject();
        test_bouncy_press();
        test_reset_mid_hold();
        test_autorepeat();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/btn_debounce_pulse.md
# btn_debounce_pulse

Conditions a raw DE1 push-button (KEY) into a clean, debounced level plus single-cycle press/release pulses on `clk`. Its `press_pulse` directly drives the `switchClock` input of the clock-switch stage, so each physical press advances the selected display/sensor clock by exactly one step regardless of contact bounce. The block provides a 2-flop synchronizer, a stability counter and a 4-state FSM.

## Interface
- `DEBOUNCE_CYCLES`, 1_000_000 (20 ms @ 50 MHz): consecutive stable synchronized samples required to accept a level change; legal range ≥ 2.
- `ACTIVE_LOW`, 1: 1 means `btn_in`=0 is "pressed" (DE1 KEY polarity); 0 means `btn_in`=1 is "pressed".
- `REPEAT_DELAY`, 25_000_000: cycles held before the first auto-repeat pulse. Used only with the macro.
- `REPEAT_PERIOD`, 10_000_000: cycles between subsequent auto-repeat pulses. Used only with the macro.
- `clk` input, 1 bit: system clock.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `btn_in` input, 1 bit: raw asynchronous button pin.
- `btn_level` output, 1 bit: debounced state; 1 = pressed, independent of `ACTIVE_LOW`.
- `press_pulse` output, 1 bit: high for exactly one `clk` cycle per accepted press (and per auto-repeat).
- `release_pulse` output, 1 bit: high for exactly one `clk` cycle per accepted release.

## Operation
- Synchronizer:
  - `btn_in` passes through two flops, then is normalized to `pressed` (1 = pressed).
  - On reset, both flops load the released level: 1 if `ACTIVE_LOW`, else 0.
- Stability counter:
  - Width is `$clog2(DEBOUNCE_CYCLES+1)`.
  - Clears whenever the normalized sample differs from the candidate level.
  - Saturates; it never wraps.
- FSM states: RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK.
  - RELEASED: if `pressed` → PRESS_CHK with count=1.
  - PRESS_CHK: if `!pressed` → RELEASED with count=0 (bounce rejected, no pulse). Else count++. When count reaches `DEBOUNCE_CYCLES` → PRESSED, assert `btn_level`, pulse `press_pulse`.
  - PRESSED: if `!pressed` → RELEASE_CHK with count=1.
  - RELEASE_CHK: if `pressed` → PRESSED (no pulse). When count reaches `DEBOUNCE_CYCLES` with `!pressed` → RELEASED, clear `btn_level`, pulse `release_pulse`.
- All outputs are registered. Nothing combinational reaches the outputs.
- `press_pulse` and `release_pulse` are never high in the same cycle.
- `btn_level` changes only in the same cycle as the corresponding pulse.

## Timing
- Reset values: `btn_level`=0, `press_pulse`=0, `release_pulse`=0, state=RELEASED, count=0, repeat counter=0.
- Latency, for `btn_in` changing between edge 0 and edge 1 and then held clean:
  - Output changes after edge `DEBOUNCE_CYCLES+2`.
  - The pulse drops after edge `DEBOUNCE_CYCLES+3`.
- Bounce shorter than `DEBOUNCE_CYCLES` cycles, in either direction, produces no output change.
- Reset asserted mid-press: outputs clear immediately (asynchronously). After deassertion, a still-held button is treated as a new press and produces one `press_pulse` after full latency.
- A press and release accepted back-to-back yields pulses at least `DEBOUNCE_CYCLES` cycles apart.

## Configuration
- `BTN_AUTOREPEAT_EN` defined:
  - In PRESSED, a repeat counter runs.
  - An extra `press_pulse` fires after `REPEAT_DELAY` cycles held, then every `REPEAT_PERIOD` cycles.
  - The counter clears on leaving PRESSED and during RELEASE_CHK bounce-back.
  - `btn_level` is unaffected.
- Undefined:
  - Exactly one `press_pulse` per accepted press.
  - No repeat counter is instantiated; `REPEAT_*` parameters are ignored.

## Structure
- Shared package `de1_io_pkg`:
  - 2-bit state encodings: RELEASED=0, PRESS_CHK=1, PRESSED=2, RELEASE_CHK=3.
  - Default `DEBOUNCE_CYCLES` and `REPEAT_*` constants for 50 MHz.
- Sub-module `sync_2ff`: generic 2-flop synchronizer with parameterized reset value. It is reused for the HC-SR04 echo input.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `ACTIVE_LOW`=1, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=3.
- Clean press: `btn_in` 1→0 between edges 0 and 1 → `btn_level`=1 and `press_pulse`=1 after edge 6; `press_pulse`=0 after edge 7; `btn_level` stays 1.
- Bounce reject: `btn_in` pulses low for 3 cycles, then returns high → no pulse; `btn_level` stays 0; FSM back in RELEASED.
- Bouncy press: alternate 0/1 every cycle for 6 cycles, then hold 0 → exactly one `press_pulse`, 6 edges after the final transition.
- Release: from held state, `btn_in` 0→1 and held → `release_pulse` one cycle, 6 edges later; `btn_level`=0 in that cycle.
- Reset mid-hold: assert `reset` while pressed → all outputs 0 immediately. Deassert with `btn_in`=0 → one `press_pulse` after full latency.
- `BTN_AUTOREPEAT_EN` (macro build): hold for 30 cycles → initial pulse plus repeats at +10, +13, +16, … cycles; releasing stops repeats. Non-macro build: the same stimulus gives a single pulse.
